sparc_exu_ecl_div_seq: RTL

- Divide-iteration sequencer in the EXU ECL. It sits directly upstream of the 6-bit iteration counter (sparc_exu_ecl_cnt6).
- Drives the counter's reset input, watches the returned count, and steps the divider datapath through one iteration per cycle.
- Runs a sign-fixup cycle when needed, then holds the result valid until writeback accepts it.
- Accepts one divide at a time from issue, with kill support.

---
 rtl/sparc_exu_ecl_div_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sparc_exu_ecl_div_seq.sv
`default_nettype none
//==============================================================================
// Module   : sparc_exu_ecl_div_seq
// Purpose  : Divide-iteration sequencer. Owns the reset of the external 6-bit
//            iteration counter, steps the divider datapath one iteration per
//            cycle, runs an optional sign-fixup cycle and holds the result
//            valid until writeback accepts it.
// Ports    : clk, reset (async, active-high)
//            div_start/div_tid/div_signed/div_kill : issue side
//            cntr                                  : count from the counter
//            wb_ack                                : writeback handshake
//            cnt_reset, div_rdy, iter_en, fix_en,
//            done_vld, done_tid                    : decoded from state only
// Option   : DIV_SEQ_PERF_CNT_EN adds div_perf_cnt[15:0], a saturating count
//            of completed (acknowledged) divides.
// Revision : 1.0  initial release
//==============================================================================
module sparc_exu_ecl_div_seq #(
    parameter int CNT_W     = 6,
    parameter int ITER_LAST = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [1:0]       div_tid,
    input  logic             div_signed,
    input  logic             div_kill,
    input  logic [CNT_W-1:0] cntr,
    input  logic             wb_ack,
    output logic             cnt_reset,
    output logic             div_rdy,
    output logic             iter_en,
    output logic             fix_en,
    output logic             done_vld,
    output logic [1:0]       done_tid
`ifdef DIV_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      div_perf_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_iter_last = CNT_W'(ITER_LAST);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_tid;
    logic       r_signed;
    // High from the second RUN cycle on; a zero count is then a missed wrap.
    logic       r_run_seen;
    logic       w_accept;

    assign w_accept = (r_state == ST_IDLE) && div_start && !div_kill;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_INIT;
            end
            ST_INIT: begin
                w_state_nxt = div_kill ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (div_kill) begin
                    w_state_nxt = ST_IDLE;
                end else if (cntr == c_iter_last) begin
                    w_state_nxt = r_signed ? ST_FIX : ST_DONE;
                end else if (r_run_seen && (cntr == c_cnt_zero)) begin
                    // Defensive exit: terminal count was skipped.
                    w_state_nxt = ST_DONE;
                end
            end
            ST_FIX: begin
                w_state_nxt = div_kill ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // Kill is ignored here: the result already belongs to writeback.
                if (wb_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latched request attributes and run tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tid      <= 2'b00;
            r_signed   <= 1'b0;
            r_run_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tid    <= div_tid;
                r_signed <= div_signed;
            end
            r_run_seen <= (r_state == ST_RUN);
        end
    end

    // Outputs are pure decodes of the registered state.
    assign cnt_reset = (r_state != ST_RUN);
    assign div_rdy   = (r_state == ST_IDLE);
    assign iter_en   = (r_state == ST_RUN);
    assign fix_en    = (r_state == ST_FIX);
    assign done_vld  = (r_state == ST_DONE);
    assign done_tid  = (r_state == ST_DONE) ? r_tid : 2'b00;

`ifdef DIV_SEQ_PERF_CNT_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cnt <= 16'h0000;
        end else if ((r_state == ST_DONE) && wb_ack && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'h0001;
        end
    end

    assign div_perf_cnt = r_perf_cnt;
`endif

endmodule
`default_nettype wire
